// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing one IO request port between two masters, with grant lock under back-pressure.
// Zero added latency on the request and return paths; an in-order owner FIFO routes read returns back to their issuer.
module io_bus_arbiter #(
  parameter int TAG_DEPTH = 4
) (
  input  logic        iCLOCK,
  input  logic        iRESET,
  // Master 0
  input  logic        iM0_REQ,
  output logic        oM0_BUSY,
  input  logic [1:0]  iM0_ORDER,
  input  logic        iM0_RW,
  input  logic [31:0] iM0_ADDR,
  input  logic [31:0] iM0_DATA,
  output logic        oM0_VALID,
  input  logic        iM0_BUSY,
  output logic [31:0] oM0_DATA,
  // Master 1
  input  logic        iM1_REQ,
  output logic        oM1_BUSY,
  input  logic [1:0]  iM1_ORDER,
  input  logic        iM1_RW,
  input  logic [31:0] iM1_ADDR,
  input  logic [31:0] iM1_DATA,
  output logic        oM1_VALID,
  input  logic        iM1_BUSY,
  output logic [31:0] oM1_DATA,
  // Peripheral interface controller side
  output logic        oIO_REQ,
  input  logic        iIO_BUSY,
  output logic [1:0]  oIO_ORDER,
  output logic        oIO_RW,
  output logic [31:0] oIO_ADDR,
  output logic [31:0] oIO_DATA,
  input  logic        iIO_VALID,
  output logic        oIO_BUSY,
  input  logic [31:0] iIO_DATA,
  output logic        oSPURIOUS
);

  localparam int PTRW = $clog2(TAG_DEPTH);
  localparam logic [PTRW:0] FULL_COUNT = (PTRW+1)'(TAG_DEPTH);

  logic                 b_last;
  logic                 b_lock;
  logic                 b_lockId;
  logic                 b_spurious;
  logic [TAG_DEPTH-1:0] b_owner;
  logic [PTRW-1:0]      b_wrPtr;
  logic [PTRW-1:0]      b_rdPtr;
  logic [PTRW:0]        b_count;

  logic readRoom;
  logic elig0;
  logic elig1;
  logic grantVld;
  logic grantId;
  logic selElig;
  logic ioReq;
  logic accept;
  logic lockedReq;
  logic fifoEmpty;
  logic headId;
  logic headBusy;
  logic push;
  logic pop;

  // Full check uses the registered count only; a same-cycle pop never frees a slot early.
  assign readRoom = (b_count < FULL_COUNT);
  assign elig0    = iM0_REQ && (!iM0_RW || readRoom);
  assign elig1    = iM1_REQ && (!iM1_RW || readRoom);

  always_comb begin
    grantVld = 1'b0;
    grantId  = 1'b0;
    if (b_lock) begin
      grantVld = 1'b1;
      grantId  = b_lockId;
    end else if (elig0 && elig1) begin
      grantVld = 1'b1;
      grantId  = ~b_last;
    end else if (elig0) begin
      grantVld = 1'b1;
      grantId  = 1'b0;
    end else if (elig1) begin
      grantVld = 1'b1;
      grantId  = 1'b1;
    end
  end

  assign selElig   = grantId ? elig1 : elig0;
  assign ioReq     = grantVld && selElig;
  assign accept    = ioReq && !iIO_BUSY;
  assign lockedReq = b_lockId ? iM1_REQ : iM0_REQ;

  assign oIO_REQ   = ioReq;
  assign oIO_ORDER = !ioReq ? 2'b00 : (grantId ? iM1_ORDER : iM0_ORDER);
  assign oIO_RW    = !ioReq ? 1'b0  : (grantId ? iM1_RW    : iM0_RW);
  assign oIO_ADDR  = !ioReq ? 32'h0 : (grantId ? iM1_ADDR  : iM0_ADDR);
  assign oIO_DATA  = !ioReq ? 32'h0 : (grantId ? iM1_DATA  : iM0_DATA);

  assign oM0_BUSY  = !(accept && !grantId);
  assign oM1_BUSY  = !(accept &&  grantId);

  assign fifoEmpty = (b_count == '0);
  assign headId    = b_owner[b_rdPtr];
  assign headBusy  = headId ? iM1_BUSY : iM0_BUSY;
  assign push      = accept && oIO_RW;
  assign pop       = iIO_VALID && !oIO_BUSY && !fifoEmpty;

  // With no owner on record the return word is dropped and never back-pressured.
  assign oIO_BUSY  = !fifoEmpty && headBusy;
  assign oM0_VALID = iIO_VALID && !fifoEmpty && !headId;
  assign oM1_VALID = iIO_VALID && !fifoEmpty &&  headId;
  assign oM0_DATA  = iIO_DATA;
  assign oM1_DATA  = iIO_DATA;
  assign oSPURIOUS = b_spurious;

  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      b_last     <= 1'b1;
      b_lock     <= 1'b0;
      b_lockId   <= 1'b0;
      b_spurious <= 1'b0;
      b_owner    <= '0;
      b_wrPtr    <= '0;
      b_rdPtr    <= '0;
      b_count    <= '0;
    end else begin
      if (ioReq && iIO_BUSY) begin
        b_lock   <= 1'b1;
        b_lockId <= grantId;
      end else if (accept || (b_lock && !lockedReq)) begin
        b_lock   <= 1'b0;
      end

      if (accept) begin
        b_last <= grantId;
      end

      if (push) begin
        b_owner[b_wrPtr] <= grantId;
        b_wrPtr          <= b_wrPtr + PTRW'(1);
      end
      if (pop) begin
        b_rdPtr <= b_rdPtr + PTRW'(1);
      end
      case ({push, pop})
        2'b10:   b_count <= b_count + (PTRW+1)'(1);
        2'b01:   b_count <= b_count - (PTRW+1)'(1);
        default: b_count <= b_count;
      endcase

      b_spurious <= iIO_VALID && fifoEmpty;
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed-vector bench for io_bus_arbiter (TAG_DEPTH = 4).
module tb_io_bus_arbiter;

  logic        iCLOCK = 1'b0;
  logic        iRESET;
  logic        iM0_REQ, iM0_RW, iM0_BUSY;
  logic [1:0]  iM0_ORDER;
  logic [31:0] iM0_ADDR, iM0_DATA;
  logic        oM0_BUSY, oM0_VALID;
  logic [31:0] oM0_DATA;
  logic        iM1_REQ, iM1_RW, iM1_BUSY;
  logic [1:0]  iM1_ORDER;
  logic [31:0] iM1_ADDR, iM1_DATA;
  logic        oM1_BUSY, oM1_VALID;
  logic [31:0] oM1_DATA;
  logic        oIO_REQ, iIO_BUSY, oIO_RW, iIO_VALID, oIO_BUSY, oSPURIOUS;
  logic [1:0]  oIO_ORDER;
  logic [31:0] oIO_ADDR, oIO_DATA, iIO_DATA;

  int vecCount = 0;
  int missCount = 0;

  io_bus_arbiter #(.TAG_DEPTH(4)) dut (
    .iCLOCK(iCLOCK), .iRESET(iRESET),
    .iM0_REQ(iM0_REQ), .oM0_BUSY(oM0_BUSY), .iM0_ORDER(iM0_ORDER), .iM0_RW(iM0_RW),
    .iM0_ADDR(iM0_ADDR), .iM0_DATA(iM0_DATA), .oM0_VALID(oM0_VALID), .iM0_BUSY(iM0_BUSY),
    .oM0_DATA(oM0_DATA),
    .iM1_REQ(iM1_REQ), .oM1_BUSY(oM1_BUSY), .iM1_ORDER(iM1_ORDER), .iM1_RW(iM1_RW),
    .iM1_ADDR(iM1_ADDR), .iM1_DATA(iM1_DATA), .oM1_VALID(oM1_VALID), .iM1_BUSY(iM1_BUSY),
    .oM1_DATA(oM1_DATA),
    .oIO_REQ(oIO_REQ), .iIO_BUSY(iIO_BUSY), .oIO_ORDER(oIO_ORDER), .oIO_RW(oIO_RW),
    .oIO_ADDR(oIO_ADDR), .oIO_DATA(oIO_DATA), .iIO_VALID(iIO_VALID), .oIO_BUSY(oIO_BUSY),
    .iIO_DATA(iIO_DATA), .oSPURIOUS(oSPURIOUS)
  );

  always #5 iCLOCK = ~iCLOCK;

  task automatic checkVec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idleAll();
    iM0_REQ = 0; iM0_RW = 0; iM0_BUSY = 0; iM0_ORDER = 2'b01; iM0_ADDR = 0; iM0_DATA = 0;
    iM1_REQ = 0; iM1_RW = 0; iM1_BUSY = 0; iM1_ORDER = 2'b10; iM1_ADDR = 0; iM1_DATA = 0;
    iIO_BUSY = 0; iIO_VALID = 0; iIO_DATA = 0;
  endtask

  task automatic m0Req(input logic rw, input logic [31:0] addr);
    iM0_REQ = 1; iM0_RW = rw; iM0_ADDR = addr; iM0_DATA = addr ^ 32'hF0F0_0000;
  endtask

  task automatic m1Req(input logic rw, input logic [31:0] addr);
    iM1_REQ = 1; iM1_RW = rw; iM1_ADDR = addr; iM1_DATA = addr ^ 32'h0F0F_0000;
  endtask

  task automatic ret(input logic [31:0] d);
    iIO_VALID = 1; iIO_DATA = d;
  endtask

  initial begin
    idleAll();
    iRESET = 1;
    tick(); tick();
    iRESET = 0;
    settle();
    // reset state
    checkVec("rst_io_req", oIO_REQ, 0);
    checkVec("rst_io_addr", oIO_ADDR, 0);
    checkVec("rst_io_data", oIO_DATA, 0);
    checkVec("rst_m0_busy", oM0_BUSY, 1);
    checkVec("rst_m1_busy", oM1_BUSY, 1);
    checkVec("rst_valids", {oM0_VALID, oM1_VALID}, 0);
    checkVec("rst_io_busy", oIO_BUSY, 0);
    checkVec("rst_spurious", oSPURIOUS, 0);

    // Continuous writes from both masters: grants alternate starting at M0.
    tick();
    m0Req(0, 32'h100);
    m1Req(0, 32'h200);
    for (int i = 0; i < 4; i++) begin
      settle();
      checkVec("alt_addr", oIO_ADDR, (i % 2 == 0) ? 32'h100 : 32'h200);
      checkVec("alt_order", oIO_ORDER, (i % 2 == 0) ? 2'b01 : 2'b10);
      checkVec("alt_busy", {oM0_BUSY, oM1_BUSY}, (i % 2 == 0) ? 2'b01 : 2'b10);
      tick();
    end
    idleAll();

    // Lock: M1 read stalled 3 cycles while M0 also requests.
    m1Req(1, 32'h204);
    iIO_BUSY = 1;
    settle();
    checkVec("lock_a_addr", oIO_ADDR, 32'h204);
    checkVec("lock_a_rw", oIO_RW, 1);
    checkVec("lock_a_busy", {oM0_BUSY, oM1_BUSY}, 2'b11);
    tick();
    m0Req(0, 32'h104);
    for (int i = 0; i < 2; i++) begin
      settle();
      checkVec("lock_hold_addr", oIO_ADDR, 32'h204);
      checkVec("lock_hold_busy", {oM0_BUSY, oM1_BUSY}, 2'b11);
      tick();
    end
    iIO_BUSY = 0;
    settle();
    checkVec("lock_acc_addr", oIO_ADDR, 32'h204);
    checkVec("lock_acc_busy", {oM0_BUSY, oM1_BUSY}, 2'b10);
    tick();
    iM1_REQ = 0;
    settle();
    checkVec("lock_m0_addr", oIO_ADDR, 32'h104);
    checkVec("lock_m0_busy", {oM0_BUSY, oM1_BUSY}, 2'b01);
    tick();
    idleAll();
    ret(32'h55);
    settle();
    checkVec("lock_ret_valid", {oM0_VALID, oM1_VALID}, 2'b01);
    checkVec("lock_ret_data", oM1_DATA, 32'h55);
    tick();
    idleAll();

    // Fill the owner FIFO with four M0 reads.
    for (int i = 0; i < 4; i++) begin
      m0Req(1, 32'h300 + 32'(i * 4));
      settle();
      checkVec("fill_acc", oM0_BUSY, 0);
      tick();
    end
    m0Req(1, 32'h310);
    m1Req(1, 32'h400);
    settle();
    checkVec("full_io_req", oIO_REQ, 0);
    checkVec("full_busy", {oM0_BUSY, oM1_BUSY}, 2'b11);
    iM0_REQ = 0;
    m1Req(0, 32'h404);
    settle();
    checkVec("full_m1_wr_addr", oIO_ADDR, 32'h404);
    checkVec("full_m1_wr_busy", oM1_BUSY, 0);
    tick();
    iM1_REQ = 0;
    m0Req(0, 32'h308);
    settle();
    checkVec("full_m0_wr_busy", oM0_BUSY, 0);
    tick();
    idleAll();
    // A same-cycle pop must not make the pending read eligible.
    m1Req(1, 32'h400);
    ret(32'hD0);
    settle();
    checkVec("full_pop_io_req", oIO_REQ, 0);
    checkVec("full_pop_valid", {oM0_VALID, oM1_VALID}, 2'b10);
    tick();
    ret(32'hD1);
    settle();
    checkVec("room_io_req", oIO_REQ, 1);
    checkVec("room_m1_busy", oM1_BUSY, 0);
    checkVec("room_valid", {oM0_VALID, oM1_VALID}, 2'b10);
    tick();
    iM1_REQ = 0;
    for (int i = 0; i < 3; i++) begin
      ret(32'hD2 + 32'(i));
      settle();
      checkVec("drain_valid", {oM0_VALID, oM1_VALID}, (i < 2) ? 2'b10 : 2'b01);
      tick();
    end
    idleAll();

    // Interleaved reads M0, M1, M0, with return back-pressure from M1.
    m0Req(1, 32'h500); tick(); idleAll();
    m1Req(1, 32'h600); tick(); idleAll();
    m0Req(1, 32'h504); tick(); idleAll();
    ret(32'hA);
    settle();
    checkVec("ilv_a_valid", {oM0_VALID, oM1_VALID}, 2'b10);
    checkVec("ilv_a_data", oM0_DATA, 32'hA);
    tick();
    ret(32'hB);
    iM1_BUSY = 1;
    for (int i = 0; i < 2; i++) begin
      settle();
      checkVec("bp_io_busy", oIO_BUSY, 1);
      checkVec("bp_valid", {oM0_VALID, oM1_VALID}, 2'b01);
      tick();
    end
    iM1_BUSY = 0;
    settle();
    checkVec("ilv_b_io_busy", oIO_BUSY, 0);
    checkVec("ilv_b_valid", {oM0_VALID, oM1_VALID}, 2'b01);
    checkVec("ilv_b_data", oM1_DATA, 32'hB);
    tick();
    ret(32'hC);
    settle();
    checkVec("ilv_c_valid", {oM0_VALID, oM1_VALID}, 2'b10);
    checkVec("ilv_c_data", oM0_DATA, 32'hC);
    tick();
    idleAll();

    // Reset with two reads outstanding: the late return is spurious.
    m0Req(1, 32'h700); tick(); idleAll();
    m1Req(1, 32'h800); tick(); idleAll();
    iRESET = 1;
    tick();
    iRESET = 0;
    ret(32'hDEAD);
    settle();
    checkVec("spur_valid", {oM0_VALID, oM1_VALID}, 2'b00);
    checkVec("spur_io_busy", oIO_BUSY, 0);
    checkVec("spur_before", oSPURIOUS, 0);
    tick();
    idleAll();
    settle();
    checkVec("spur_pulse", oSPURIOUS, 1);
    tick();
    settle();
    checkVec("spur_after", oSPURIOUS, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
